// File: rtl/lr_coef_solver_pkg.sv
// Shared definitions for the least-squares coefficient solver: default widths and FSM states.
// The optional intercept path is enabled by defining LR_INTERCEPT_EN.
package lr_coef_solver_pkg;

    localparam int LR_NW   = 16;
    localparam int LR_AW   = 32;
    localparam int LR_OW   = 32;
    localparam int LR_FRAC = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL_A = 3'd1,
        ST_MUL_B = 3'd2,
        ST_MUL_C = 3'd3,
        ST_CHECK = 3'd4,
        ST_DIV_M = 3'd5,
        ST_DIV_B = 3'd6,
        ST_DONE  = 3'd7
    } lr_state_t;

endpackage

// File: rtl/lr_coef_solver_seq_div.sv
// Unsigned restoring divider producing a QW-bit quotient, one bit per cycle, MSB first.
// o_last/o_quot_next expose the final bit one edge early so a second divide can start back-to-back.
module lr_seq_div #(
    parameter int DW = 97,
    parameter int VW = 65,
    parameter int QW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic [DW-1:0] i_dividend,
    input  logic [VW-1:0] i_divisor,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_last,
    output logic [QW-1:0] o_quot,
    output logic [QW-1:0] o_quot_next
);

    localparam int CW = $clog2(QW + 1);

    logic [DW-1:0] r_rem;
    logic [DW-1:0] r_div_sh;
    logic [QW-1:0] r_quot;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;

    logic          w_ge;
    logic [DW-1:0] w_rem_next;

    // Divisor starts aligned to the quotient MSB and walks right one bit per iteration.
    assign w_ge        = (r_rem >= r_div_sh);
    assign w_rem_next  = w_ge ? (r_rem - r_div_sh) : r_rem;
    assign o_quot_next = {r_quot[QW-2:0], w_ge};
    assign o_last      = r_busy && (r_cnt == CW'(QW - 1));
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_quot      = r_quot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem    <= '0;
            r_div_sh <= '0;
            r_quot   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_start) begin
            r_rem    <= i_dividend;
            r_div_sh <= DW'(i_divisor) << (QW - 1);
            r_quot   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                r_rem    <= w_rem_next;
                r_div_sh <= r_div_sh >> 1;
                r_quot   <= o_quot_next;
                r_cnt    <= r_cnt + 1'b1;
                if (o_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lr_coef_solver.sv
// Least-squares slope (and optional intercept) solver over accumulated regression sums.
// Define LR_INTERCEPT_EN to add the intercept computation (MUL_C / DIV_B states).
module lr_coef_solver
    import lr_coef_solver_pkg::*;
#(
    parameter int NW   = LR_NW,
    parameter int AW   = LR_AW,
    parameter int OW   = LR_OW,
    parameter int FRAC = LR_FRAC
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NW-1:0]        n,
    input  logic signed [AW-1:0] sum_x,
    input  logic signed [AW-1:0] sum_y,
    input  logic signed [AW-1:0] sum_xx,
    input  logic signed [AW-1:0] sum_xy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OW-1:0]        slope,
    output logic [OW-1:0]        intercept,
    output logic                 err,
    output logic                 sat
);

    localparam int PW = 2 * AW + 1;
    localparam int DW = PW + OW;
    localparam logic [OW-1:0] SAT_POS = {1'b0, {(OW - 1){1'b1}}};
    localparam logic [OW-1:0] SAT_NEG = {1'b1, {(OW - 1){1'b0}}};

    function automatic logic [OW-1:0] f_apply_sign(input logic i_neg, input logic [OW-1:0] i_q);
        return i_neg ? (~i_q + 1'b1) : i_q;
    endfunction

    lr_state_t r_state;
    lr_state_t w_state_next;

    logic [NW-1:0]        r_n;
    logic signed [AW-1:0] r_sum_x, r_sum_y, r_sum_xx, r_sum_xy;
    logic signed [PW-1:0] r_p1, r_p2, r_num, r_den;
    logic [OW-1:0]        r_slope;
    logic                 r_err, r_sat;

    logic signed [PW-1:0] w_a0, w_b0, w_a1, w_b1, w_mul0, w_mul1;
    logic                 w_num_neg, w_den_bad, w_clip_m, w_clip_all;
    logic [PW-1:0]        w_num_mag;
    logic [DW-1:0]        w_num_scaled, w_den_lim;

    logic                 w_div_start, w_div_busy, w_div_done, w_div_last;
    logic [DW-1:0]        w_div_dividend;
    logic [OW-1:0]        w_div_quot, w_div_quot_next;
    logic                 w_unused;

`ifdef LR_INTERCEPT_EN
    logic signed [PW-1:0] r_numb;
    logic [OW-1:0]        r_intercept;
    logic                 r_clip_m, r_clip_b;
    logic                 w_numb_neg, w_clip_b;
    logic [PW-1:0]        w_numb_mag;
    logic [DW-1:0]        w_numb_scaled;

    assign w_numb_neg    = r_numb[PW-1];
    assign w_numb_mag    = w_numb_neg ? $unsigned(-r_numb) : $unsigned(r_numb);
    assign w_numb_scaled = DW'(w_numb_mag) << FRAC;
    assign w_clip_b      = (w_numb_scaled >= w_den_lim);
    assign w_clip_all    = w_clip_m && w_clip_b;
    assign intercept     = r_intercept;
    assign w_unused      = w_div_busy;
`else
    assign w_clip_all    = w_clip_m;
    assign intercept     = '0;
    assign w_unused      = ^{w_div_busy, w_div_last, w_div_quot_next};
`endif

    // Two multipliers, operands steered by state so each product pair reuses the same hardware.
    always_comb begin
        w_a0 = PW'(r_sum_x);
        w_b0 = PW'(r_sum_y);
        w_a1 = PW'(r_sum_x);
        w_b1 = PW'(r_sum_x);
        if (r_state == ST_MUL_A) begin
            w_a0 = PW'(r_n);
            w_b0 = PW'(r_sum_xy);
            w_a1 = PW'(r_n);
            w_b1 = PW'(r_sum_xx);
        end
`ifdef LR_INTERCEPT_EN
        if (r_state == ST_MUL_C) begin
            w_a0 = PW'(r_sum_y);
            w_b0 = PW'(r_sum_xx);
            w_a1 = PW'(r_sum_x);
            w_b1 = PW'(r_sum_xy);
        end
`endif
    end

    assign w_mul0 = w_a0 * w_b0;
    assign w_mul1 = w_a1 * w_b1;

    assign w_num_neg    = r_num[PW-1];
    assign w_num_mag    = w_num_neg ? $unsigned(-r_num) : $unsigned(r_num);
    assign w_num_scaled = DW'(w_num_mag) << FRAC;
    assign w_den_lim    = DW'($unsigned(r_den)) << (OW - 1);
    assign w_den_bad    = r_den[PW-1] || (r_den == '0);
    assign w_clip_m     = (w_num_scaled >= w_den_lim);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        w_div_start    = 1'b0;
        w_div_dividend = w_num_scaled;
        case (r_state)
            ST_IDLE:  if (in_valid) w_state_next = ST_MUL_A;
            ST_MUL_A: w_state_next = ST_MUL_B;
`ifdef LR_INTERCEPT_EN
            ST_MUL_B: w_state_next = ST_MUL_C;
            ST_MUL_C: w_state_next = ST_CHECK;
`else
            ST_MUL_B: w_state_next = ST_CHECK;
`endif
            ST_CHECK: begin
                if (w_den_bad || w_clip_all) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_div_start  = 1'b1;
                    w_state_next = ST_DIV_M;
                end
            end
`ifdef LR_INTERCEPT_EN
            // Intercept divide is launched on the slope divide's final edge: no idle cycle between.
            ST_DIV_M: begin
                if (w_div_last) begin
                    w_div_start    = 1'b1;
                    w_div_dividend = w_numb_scaled;
                    w_state_next   = ST_DIV_B;
                end
            end
            ST_DIV_B: if (w_div_done) w_state_next = ST_DONE;
`else
            ST_DIV_M: if (w_div_done) w_state_next = ST_DONE;
`endif
            ST_DONE:  if (out_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_n      <= '0;
            r_sum_x  <= '0;
            r_sum_y  <= '0;
            r_sum_xx <= '0;
            r_sum_xy <= '0;
            r_p1     <= '0;
            r_p2     <= '0;
            r_num    <= '0;
            r_den    <= '0;
            r_slope  <= '0;
            r_err    <= 1'b0;
            r_sat    <= 1'b0;
`ifdef LR_INTERCEPT_EN
            r_numb      <= '0;
            r_intercept <= '0;
            r_clip_m    <= 1'b0;
            r_clip_b    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_n      <= n;
                        r_sum_x  <= sum_x;
                        r_sum_y  <= sum_y;
                        r_sum_xx <= sum_xx;
                        r_sum_xy <= sum_xy;
                        r_err    <= 1'b0;
                        r_sat    <= 1'b0;
                    end
                end
                ST_MUL_A: begin
                    r_p1 <= w_mul0;
                    r_p2 <= w_mul1;
                end
                ST_MUL_B: begin
                    r_num <= r_p1 - w_mul0;
                    r_den <= r_p2 - w_mul1;
                end
`ifdef LR_INTERCEPT_EN
                ST_MUL_C: r_numb <= w_mul0 - w_mul1;
`endif
                ST_CHECK: begin
                    if (w_den_bad) begin
                        r_err   <= 1'b1;
                        r_slope <= '0;
`ifdef LR_INTERCEPT_EN
                        r_intercept <= '0;
`endif
                    end else begin
                        if (w_clip_m) r_slope <= w_num_neg ? SAT_NEG : SAT_POS;
`ifdef LR_INTERCEPT_EN
                        if (w_clip_b) r_intercept <= w_numb_neg ? SAT_NEG : SAT_POS;
                        r_clip_m <= w_clip_m;
                        r_clip_b <= w_clip_b;
                        r_sat    <= w_clip_m | w_clip_b;
`else
                        r_sat    <= w_clip_m;
`endif
                    end
                end
`ifdef LR_INTERCEPT_EN
                ST_DIV_M: if (w_div_last && !r_clip_m) r_slope <= f_apply_sign(w_num_neg, w_div_quot_next);
                ST_DIV_B: if (w_div_done && !r_clip_b) r_intercept <= f_apply_sign(w_numb_neg, w_div_quot);
`else
                ST_DIV_M: if (w_div_done) r_slope <= f_apply_sign(w_num_neg, w_div_quot);
`endif
                default: ;
            endcase
        end
    end

    lr_seq_div #(
        .DW (DW),
        .VW (PW),
        .QW (OW)
    ) u_div (
        .clk         (clk),
        .rst_n       (reset),
        .i_start     (w_div_start),
        .i_dividend  (w_div_dividend),
        .i_divisor   ($unsigned(r_den)),
        .o_busy      (w_div_busy),
        .o_done      (w_div_done),
        .o_last      (w_div_last),
        .o_quot      (w_div_quot),
        .o_quot_next (w_div_quot_next)
    );

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign slope     = r_slope;
    assign err       = r_err;
    assign sat       = r_sat;

endmodule

// File: tb/tb_lr_coef_solver.sv
// Directed self-checking bench for lr_coef_solver; expectations follow LR_INTERCEPT_EN when defined.
`timescale 1ns/1ps
module tb_lr_coef_solver;

    localparam int NW = 16;
    localparam int AW = 32;
    localparam int OW = 32;
    localparam int BUDGET = 200;
`ifdef LR_INTERCEPT_EN
    localparam int          LAT    = 5 + 2 * OW;
    localparam logic [31:0] EXP_B1 = 32'h0000_0100;
`else
    localparam int          LAT    = 4 + OW;
    localparam logic [31:0] EXP_B1 = 32'h0000_0000;
`endif

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b0;
    logic                 in_ready, out_valid, err, sat;
    logic [NW-1:0]        n = '0;
    logic signed [AW-1:0] sum_x = '0, sum_y = '0, sum_xx = '0, sum_xy = '0;
    logic [OW-1:0]        slope, intercept;

    int tests = 0;
    int fails = 0;
    int lat;
    logic seen;

    always #5 clk = ~clk;

    lr_coef_solver dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n         (n),
        .sum_x     (sum_x),
        .sum_y     (sum_y),
        .sum_xx    (sum_xx),
        .sum_xy    (sum_xy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .slope     (slope),
        .intercept (intercept),
        .err       (err),
        .sat       (sat)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input logic [15:0] vn, input logic signed [31:0] vx, vy, vxx, vxy);
        n = vn; sum_x = vx; sum_y = vy; sum_xx = vxx; sum_xy = vxy;
    endtask

    // Called at posedge+1; returns at accept edge+1 with in_valid dropped.
    task automatic send(input logic [15:0] vn, input logic signed [31:0] vx, vy, vxx, vxy);
        set_inputs(vn, vx, vy, vxx, vxy);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < BUDGET) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic run_case(input string tag, input logic [15:0] vn, input logic signed [31:0] vx, vy, vxx, vxy,
                            input logic [31:0] es, eb, input logic ee, esat, output int cycles);
        send(vn, vx, vy, vxx, vxy);
        chk({tag, ".in_ready_low"}, in_ready, 1'b0);
        wait_out(cycles);
        chk({tag, ".done_in_budget"}, cycles < BUDGET, 1'b1);
        chk({tag, ".slope"}, slope, es);
        chk({tag, ".intercept"}, intercept, eb);
        chk({tag, ".err"}, err, ee);
        chk({tag, ".sat"}, sat, esat);
        $display("[TB] %s: lat=%0d slope=0x%08h intercept=0x%08h err=%0b sat=%0b",
                 tag, cycles, slope, intercept, err, sat);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".out_valid_cleared"}, out_valid, 1'b0);
        chk({tag, ".in_ready_back"}, in_ready, 1'b1);
    endtask

    initial begin
        // Async reset before any clock edge
        #2 reset = 1'b0;
        #1;
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.slope", slope, 32'h0);
        chk("rst.intercept", intercept, 32'h0);
        chk("rst.err", err, 1'b0);
        chk("rst.sat", sat, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        run_case("c1.y2x1", 16'd4, 32'sd10, 32'sd24, 32'sd30, 32'sd70, 32'h0000_0200, EXP_B1, 1'b0, 1'b0, lat);
        chk("c1.latency", lat, LAT);

        run_case("c2.neg_half", 16'd2, 32'sd2, -32'sd1, 32'sd4, -32'sd2, 32'hFFFF_FF80, 32'h0, 1'b0, 1'b0, lat);
        chk("c2.latency", lat, LAT);

        run_case("c3.degenerate", 16'd3, 32'sd15, 32'sd9, 32'sd75, 32'sd45, 32'h0, 32'h0, 1'b1, 1'b0, lat);

        run_case("c4.saturate", 16'd2, 32'sd1, 32'sd16777216, 32'sd1, 32'sd16777216, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, lat);

        // Backpressure: hold out_ready low, inject an in_valid pulse that must be dropped
        send(16'd4, 32'sd10, 32'sd24, 32'sd30, 32'sd70);
        wait_out(lat);
        chk("c5.done_in_budget", lat < BUDGET, 1'b1);
        chk("c5.sat_cleared", sat, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                set_inputs(16'd2, 32'sd1, 32'sd16777216, 32'sd1, 32'sd16777216);
                in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("c5.hold%0d.out_valid", i), out_valid, 1'b1);
            chk($sformatf("c5.hold%0d.in_ready", i), in_ready, 1'b0);
            chk($sformatf("c5.hold%0d.slope", i), slope, 32'h0000_0200);
        end
        $display("[TB] c5.hold: slope=0x%08h held for 10 cycles", slope);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("c5.out_valid_cleared", out_valid, 1'b0);
        chk("c5.in_ready_back", in_ready, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < LAT + 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("c5.no_queued_result", seen, 1'b0);

        // Reset in the middle of the slope divide
        send(16'd4, 32'sd10, 32'sd24, 32'sd30, 32'sd70);
        repeat (10) @(posedge clk);
        #1;
        chk("c6.busy_before_reset", out_valid, 1'b0);
        reset = 1'b0;
        #1;
        chk("c6.rst.in_ready", in_ready, 1'b1);
        chk("c6.rst.out_valid", out_valid, 1'b0);
        chk("c6.rst.slope", slope, 32'h0);
        chk("c6.rst.intercept", intercept, 32'h0);
        chk("c6.rst.err", err, 1'b0);
        chk("c6.rst.sat", sat, 1'b0);
        $display("[TB] c6.reset: in_ready=%0b slope=0x%08h", in_ready, slope);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_case("c6.rerun", 16'd4, 32'sd10, 32'sd24, 32'sd30, 32'sd70, 32'h0000_0200, EXP_B1, 1'b0, 1'b0, lat);
        chk("c6.latency", lat, LAT);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
